datapath_sequencer: RTL and testbench
=====================================

# datapath_sequencer

Instruction sequencer and initiator for the register-file/ALU datapath. Fetches 32-bit words from an instruction memory over a req/ack handshake, decodes them, and drives every datapath control input (op, form, vec, operand/destination indices, zero_reg, write, const_a, constant). Sits between the instruction memory port and the datapath.

## Interface
- ADDR_W, 16, instruction address / PC width
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  pulse; starts execution at start_pc from IDLE or HALT
- start_pc  in  ADDR_W  entry address, sampled with start
- imem_req  out  1  fetch request, held high until imem_ack
- imem_addr  out  ADDR_W  fetch address, equal to pc while imem_req=1
- imem_ack  in  1  fetch complete; imem_data valid in the same cycle
- imem_data  in  32  fetched word
- op  out  3; form  out  1; vec  out  2  ALU control
- A, B, C, D  out  4 each  source register indices
- Y1, Y2  out  4 each  destination register indices
- zero_reg  out  4  per-source force-to-zero (bit0=A ... bit3=D)
- write  out  2  register write enables (bit0=Y1, bit1=Y2)
- const_a  out  1  selects constant as source A
- constant  out  32  literal loaded by LDC
- pc  out  ADDR_W  current fetch address
- halted  out  1  high in HALT state

## Operation
- ALU word layout: op[31:29] form[28] vec[27:26] A[25:22] B[21:18] C[17:14] D[13:10] Y1[9:6] Y2[5:2] write[1:0].
- Control word: bits[31:28]=4'hF (op=7, form=1 reserved). kind[27:26]: 00 HALT, 01 LDC (next word is the constant), 10 JMP to [ADDR_W-1:0], 11 NOP.
- zero_reg[i] is 1 when the corresponding source index is 4'hF. r15 is therefore never readable, but remains writable.
- States: IDLE, FETCH, CFETCH, EXEC, HALT.
- IDLE:
  - start -> pc=start_pc -> FETCH.
- FETCH: imem_req=1. On ack:
  - ALU word: register all fields, pc+1 -> EXEC.
  - LDC: pc+1 -> CFETCH.
  - JMP: pc=target -> FETCH.
  - NOP: pc+1 -> FETCH.
  - HALT: clear const_pending -> HALT. pc is not incremented.
- CFETCH: imem_req=1. On ack:
  - constant=imem_data, const_pending=1, pc+1 -> FETCH.
- EXEC (exactly one cycle):
  - write=registered write field; const_a=const_pending.
  - Clear const_pending -> FETCH.
- HALT:
  - halted=1.
  - start -> pc=start_pc, halted=0 -> FETCH.
- const_pending survives NOP and JMP and is consumed only by the next ALU word. A second LDC overwrites constant.
- Field outputs (op..Y2, zero_reg) hold their value until the next ALU word is accepted.
- write is 0 in every state except EXEC.
- const_a is 0 outside EXEC.
- pc wraps FFFF->0000 with no flag.
- start outside IDLE/HALT is ignored.
- imem_ack while imem_req=0 is ignored.
- rst mid-fetch abandons the outstanding request; imem_req drops immediately (asynchronously).

## Timing
- Reset values: state=IDLE, pc=0, imem_req=0, halted=0, constant=0, const_pending=0, all datapath control outputs 0.
- imem_req and imem_addr are registered outputs. An ack may arrive in the first req cycle (zero-wait).
- ALU word, zero-wait memory: 2 cycles (FETCH, EXEC). Throughput is one ALU op per 2 cycles.
- LDC+ALU: 4 cycles.
- Datapath writes on the clock edge ending EXEC; the next FETCH starts in the following cycle.
- Memory wait states extend FETCH/CFETCH only. Outputs are stable while waiting.
- start -> first imem_req: 1 cycle.

## Structure
- Package datapath_seq_pkg holds:
  - state enum;
  - control-kind constants (HALT/LDC/JMP/NOP);
  - field bit positions;
  - CTRL_PREFIX=4'hF;
  - ZERO_IDX=4'hF.
- Sub-module seq_decode is purely combinational: imem_data -> {is_ctrl, kind, field bundle, zero_reg}. The FSM and registers live in datapath_sequencer.

## Test plan
- Reset, then start with start_pc=0x0010 and zero-wait memory holding ALU word 0x2A4C_8C65:
  - imem_addr=0x0010 one cycle after start.
  - EXEC cycle shows op=1, form=0, vec=2, write=2'b01, const_a=0.
- LDC at 0x0000, constant 0xDEADBEEF at 0x0001, NOP at 0x0002, ALU word with A=4'hF at 0x0003:
  - EXEC shows const_a=1, constant=0xDEADBEEF, zero_reg[0]=1.
  - A following ALU word shows const_a=0.
- JMP 0x0100 at 0x0005 with 3 wait states per fetch:
  - imem_req held 4 cycles per fetch.
  - Next imem_addr=0x0100.
  - write stays 0 throughout.
- HALT at 0x0007:
  - halted=1, imem_req=0.
  - A start pulse while running is ignored.
  - start with start_pc=0x0020 after HALT resumes fetching at 0x0020.
- pc=0xFFFF holding NOP:
  - Next fetch address is 0x0000.
- Assert rst during a pending fetch with imem_req=1:
  - imem_req=0 and all outputs at reset values immediately.
  - A late imem_ack is ignored.

Source files
------------

// File: rtl/datapath_seq_pkg.sv
// Shared types and encodings for the datapath instruction sequencer.
// Instruction word layout, control-word kinds and FSM states.
package datapath_seq_pkg;

   localparam logic [3:0] CTRL_PREFIX = 4'hF;
   localparam logic [3:0] ZERO_IDX    = 4'hF;

   localparam int unsigned PREFIX_LSB = 28;
   localparam int unsigned KIND_LSB   = 26;
   localparam int unsigned OP_LSB     = 29;
   localparam int unsigned FORM_BIT   = 28;
   localparam int unsigned VEC_LSB    = 26;
   localparam int unsigned A_LSB      = 22;
   localparam int unsigned B_LSB      = 18;
   localparam int unsigned C_LSB      = 14;
   localparam int unsigned D_LSB      = 10;
   localparam int unsigned Y1_LSB     = 6;
   localparam int unsigned Y2_LSB     = 2;
   localparam int unsigned WR_LSB     = 0;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_CFETCH,
      S_EXEC,
      S_HALT
   } state_e;

   typedef enum logic [1:0] {
      K_HALT = 2'b00,
      K_LDC  = 2'b01,
      K_JMP  = 2'b10,
      K_NOP  = 2'b11
   } ctrl_kind_e;

   typedef struct packed {
      logic [2:0] op;
      logic       form;
      logic [1:0] vec;
      logic [3:0] a;
      logic [3:0] b;
      logic [3:0] c;
      logic [3:0] d;
      logic [3:0] y1;
      logic [3:0] y2;
      logic [1:0] wr;
   } alu_fields_t;

endpackage

// File: rtl/seq_decode.sv
// Combinational instruction decoder: splits a fetched word into control
// kind, ALU field bundle and per-source zero flags.
module seq_decode
   import datapath_seq_pkg::*;
(
   input  logic [31:0] i_data,
   output logic        o_is_ctrl,
   output logic [1:0]  o_kind,
   output logic [31:0] o_fields,
   output logic [3:0]  o_zero_reg
);

   alu_fields_t w_f;

   always_comb begin
      w_f      = '0;
      w_f.op   = i_data[OP_LSB +: 3];
      w_f.form = i_data[FORM_BIT];
      w_f.vec  = i_data[VEC_LSB +: 2];
      w_f.a    = i_data[A_LSB +: 4];
      w_f.b    = i_data[B_LSB +: 4];
      w_f.c    = i_data[C_LSB +: 4];
      w_f.d    = i_data[D_LSB +: 4];
      w_f.y1   = i_data[Y1_LSB +: 4];
      w_f.y2   = i_data[Y2_LSB +: 4];
      w_f.wr   = i_data[WR_LSB +: 2];
   end

   assign o_is_ctrl  = (i_data[PREFIX_LSB +: 4] == CTRL_PREFIX);
   assign o_kind     = i_data[KIND_LSB +: 2];
   assign o_fields   = w_f;
   assign o_zero_reg = {w_f.d == ZERO_IDX, w_f.c == ZERO_IDX,
                        w_f.b == ZERO_IDX, w_f.a == ZERO_IDX};

endmodule

// File: rtl/datapath_sequencer.sv
// Instruction fetch/decode sequencer driving the register-file/ALU datapath
// controls from words fetched over a req/ack instruction memory port.
module datapath_sequencer
   import datapath_seq_pkg::*;
#(
   parameter int unsigned ADDR_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] start_pc,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [31:0]       imem_data,
   output logic [2:0]        op,
   output logic              form,
   output logic [1:0]        vec,
   output logic [3:0]        A,
   output logic [3:0]        B,
   output logic [3:0]        C,
   output logic [3:0]        D,
   output logic [3:0]        Y1,
   output logic [3:0]        Y2,
   output logic [3:0]        zero_reg,
   output logic [1:0]        write,
   output logic              const_a,
   output logic [31:0]       constant,
   output logic [ADDR_W-1:0] pc,
   output logic              halted
);

   state_e            r_state;
   logic [ADDR_W-1:0] r_pc;
   logic              r_req;
   alu_fields_t       r_fields;
   logic [3:0]        r_zero;
   logic [31:0]       r_constant;
   logic              r_pending;

   state_e            w_state_nxt;
   logic [ADDR_W-1:0] w_pc_nxt;
   logic [ADDR_W-1:0] w_pc_inc;
   logic              w_req_nxt;
   logic              w_pend_nxt;
   logic              w_ld_fields;
   logic              w_ld_const;
   logic              w_ack;
   logic              w_is_ctrl;
   logic [1:0]        w_kind_raw;
   ctrl_kind_e        w_kind;
   logic [31:0]       w_fields_raw;
   logic [3:0]        w_zero;

   seq_decode u_decode (
      .i_data     (imem_data),
      .o_is_ctrl  (w_is_ctrl),
      .o_kind     (w_kind_raw),
      .o_fields   (w_fields_raw),
      .o_zero_reg (w_zero)
   );

   assign w_kind   = ctrl_kind_e'(w_kind_raw);
   // Only an ack against our own outstanding request counts.
   assign w_ack    = imem_ack & r_req;
   assign w_pc_inc = r_pc + ADDR_W'(1);

   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_req_nxt   = 1'b0;
      w_pend_nxt  = r_pending;
      w_ld_fields = 1'b0;
      w_ld_const  = 1'b0;
      case (r_state)
         S_IDLE, S_HALT: begin
            if (start) begin
               w_pc_nxt    = start_pc;
               w_req_nxt   = 1'b1;
               w_state_nxt = S_FETCH;
            end
         end
         S_FETCH: begin
            w_req_nxt = 1'b1;
            if (w_ack) begin
               if (!w_is_ctrl) begin
                  w_ld_fields = 1'b1;
                  w_pc_nxt    = w_pc_inc;
                  w_req_nxt   = 1'b0;
                  w_state_nxt = S_EXEC;
               end else begin
                  case (w_kind)
                     K_LDC: begin
                        w_pc_nxt    = w_pc_inc;
                        w_state_nxt = S_CFETCH;
                     end
                     K_JMP:   w_pc_nxt = imem_data[ADDR_W-1:0];
                     K_NOP:   w_pc_nxt = w_pc_inc;
                     default: begin
                        w_pend_nxt  = 1'b0;
                        w_req_nxt   = 1'b0;
                        w_state_nxt = S_HALT;
                     end
                  endcase
               end
            end
         end
         S_CFETCH: begin
            w_req_nxt = 1'b1;
            if (w_ack) begin
               w_ld_const  = 1'b1;
               w_pend_nxt  = 1'b1;
               w_pc_nxt    = w_pc_inc;
               w_state_nxt = S_FETCH;
            end
         end
         S_EXEC: begin
            w_pend_nxt  = 1'b0;
            w_req_nxt   = 1'b1;
            w_state_nxt = S_FETCH;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_pc       <= '0;
         r_req      <= 1'b0;
         r_fields   <= '0;
         r_zero     <= '0;
         r_constant <= '0;
         r_pending  <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_pc      <= w_pc_nxt;
         r_req     <= w_req_nxt;
         r_pending <= w_pend_nxt;
         if (w_ld_fields) begin
            r_fields <= alu_fields_t'(w_fields_raw);
            r_zero   <= w_zero;
         end
         if (w_ld_const) begin
            r_constant <= imem_data;
         end
      end
   end

   assign imem_req  = r_req;
   assign imem_addr = r_pc;
   assign pc        = r_pc;
   assign halted    = (r_state == S_HALT);
   assign op        = r_fields.op;
   assign form      = r_fields.form;
   assign vec       = r_fields.vec;
   assign A         = r_fields.a;
   assign B         = r_fields.b;
   assign C         = r_fields.c;
   assign D         = r_fields.d;
   assign Y1        = r_fields.y1;
   assign Y2        = r_fields.y2;
   assign zero_reg  = r_zero;
   assign write     = (r_state == S_EXEC) ? r_fields.wr : '0;
   assign const_a   = (r_state == S_EXEC) & r_pending;
   assign constant  = r_constant;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Scoreboard bench: an instruction-level model walks each program up front and
// queues expected fetch addresses and EXEC outcomes; a monitor checks the DUT.
module tb_datapath_sequencer;

   localparam logic [31:0] W_HALT = 32'hF000_0000;
   localparam logic [31:0] W_LDC  = 32'hF400_0000;
   localparam logic [31:0] W_JMP  = 32'hF800_0000;
   localparam logic [31:0] W_NOP  = 32'hFC00_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [15:0] start_pc = '0;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_data = '0;
   logic [2:0]  op;
   logic        form;
   logic [1:0]  vec;
   logic [3:0]  A, B, C, D, Y1, Y2, zero_reg;
   logic [1:0]  write;
   logic        const_a;
   logic [31:0] constant;
   logic [15:0] pc;
   logic        halted;

   datapath_sequencer #(.ADDR_W(16)) dut (
      .clk(clk), .rst(rst), .start(start), .start_pc(start_pc),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
      .imem_data(imem_data), .op(op), .form(form), .vec(vec),
      .A(A), .B(B), .C(C), .D(D), .Y1(Y1), .Y2(Y2), .zero_reg(zero_reg),
      .write(write), .const_a(const_a), .constant(constant), .pc(pc),
      .halted(halted)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] word;
      logic        ca;
      logic [31:0] k;
   } exec_t;

   logic [31:0] mem [0:65535];
   logic [15:0] exp_fetch [$];
   exec_t       exp_exec [$];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          mem_wait = 0;
   logic        mem_en   = 1'b1;

   logic        m_pending = 1'b0;
   logic [31:0] m_const   = '0;
   logic [31:0] m_last    = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic unexpected(input string name, input logic [63:0] act);
      n_checks++;
      n_fail++;
      $display("FAIL %s: got 0x%0h with nothing expected at %0t", name, act, $time);
   endtask

   function automatic logic [3:0] zero_of(input logic [31:0] w);
      return {w[13:10] == 4'hF, w[17:14] == 4'hF, w[21:18] == 4'hF, w[25:22] == 4'hF};
   endfunction

   function automatic logic [31:0] rand_alu();
      logic [31:0] w;
      w = $urandom;
      if (w[31:28] == 4'hF) w[28] = 1'b0;
      if (w[1:0] == 2'b00) w[0] = 1'b1;
      if ($urandom_range(3) == 0) w[25:22] = 4'hF;
      return w;
   endfunction

   task automatic check_fields(input string name, input logic [31:0] w);
      chk(name, {op, form, vec, A, B, C, D, Y1, Y2}, w[31:2]);
      chk({name, "_zero"}, zero_reg, zero_of(w));
   endtask

   // Instruction-level execution of the program from spc until HALT.
   task automatic model_run(input logic [15:0] spc);
      logic [15:0] p;
      logic [31:0] w;
      exec_t       e;
      p = spc;
      for (int steps = 0; steps < 4096; steps++) begin
         w = mem[p];
         exp_fetch.push_back(p);
         if (w[31:28] == 4'hF) begin
            case (w[27:26])
               2'b00: begin m_pending = 1'b0; return; end
               2'b01: begin
                  p = p + 16'd1;
                  exp_fetch.push_back(p);
                  m_const   = mem[p];
                  m_pending = 1'b1;
                  p = p + 16'd1;
               end
               2'b10:   p = w[15:0];
               default: p = p + 16'd1;
            endcase
         end else begin
            e.word = w; e.ca = m_pending; e.k = m_const;
            exp_exec.push_back(e);
            m_last    = w;
            m_pending = 1'b0;
            p = p + 16'd1;
         end
      end
   endtask

   // Memory responder: ack after mem_wait idle request cycles.
   initial begin : responder
      int cnt = 0;
      forever begin
         @(negedge clk);
         if (mem_en) begin
            if (!imem_req) begin
               imem_ack = 1'b0; cnt = 0;
            end else begin
               if (imem_ack) cnt = 0;
               if (cnt >= mem_wait) begin
                  imem_ack = 1'b1; imem_data = mem[imem_addr];
               end else begin
                  imem_ack = 1'b0; imem_data = $urandom; cnt++;
               end
            end
         end
      end
   end

   initial begin : monitor
      int    run = 0;
      exec_t e;
      forever begin
         @(negedge clk); #2;
         if (rst || !imem_req) run = 0;
         else run++;
         if (!rst && imem_req && imem_ack) begin
            chk("fetch_len", run, mem_wait + 1);
            run = 0;
            if (exp_fetch.size() == 0) unexpected("fetch_addr", imem_addr);
            else chk("fetch_addr", imem_addr, exp_fetch.pop_front());
         end
         if (write != 2'b00 || const_a) begin
            if (exp_exec.size() == 0) unexpected("exec_event", {write, const_a});
            else begin
               e = exp_exec.pop_front();
               check_fields("exec_fields", e.word);
               chk("exec_write", write, e.word[1:0]);
               chk("exec_const_a", const_a, e.ca);
               chk("exec_constant", constant, e.k);
            end
         end
      end
   end

   task automatic start_prog(input logic [15:0] base);
      model_run(base);
      @(posedge clk); #1 start = 1'b1; start_pc = base;
      @(posedge clk); #1 start = 1'b0;
      chk("start_req", imem_req, 1'b1);
      chk("start_addr", imem_addr, base);
      chk("start_halted", halted, 1'b0);
   endtask

   task automatic wait_halt(input string name);
      for (int i = 0; i < 3000 && !halted; i++) begin
         @(posedge clk); #1;
      end
      chk({name, "_halted"}, halted, 1'b1);
      chk({name, "_req"}, imem_req, 1'b0);
      chk({name, "_write"}, {write, const_a}, 3'b000);
      chk({name, "_fetch_left"}, exp_fetch.size(), 0);
      chk({name, "_exec_left"}, exp_exec.size(), 0);
      check_fields({name, "_hold"}, m_last);
      chk({name, "_const"}, constant, m_const);
      exp_fetch.delete();
      exp_exec.delete();
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      logic [31:0] w;
      logic [15:0] base, p;
      int          g;

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check_fields("rst_fields", '0);
      chk("rst_misc", {pc, imem_req, halted, write, const_a}, '0);
      chk("rst_const", constant, '0);

      // Plan ALU word with zero-wait memory, explicit EXEC cycle checks.
      mem_wait = 0;
      mem[16'h0010] = 32'h2A4C_8C65;
      mem[16'h0011] = W_HALT;
      start_prog(16'h0010);
      @(posedge clk); #1;
      chk("exec1_ctl", {op, form, vec, write, const_a}, {3'd1, 1'b0, 2'd2, 2'b01, 1'b0});
      chk("exec1_req", imem_req, 1'b0);
      @(posedge clk); #1;
      chk("exec1_next", {imem_req, imem_addr}, {1'b1, 16'h0011});
      wait_halt("t1");

      // LDC/NOP/JMP program with 3 wait states and an ignored start pulse.
      mem_wait = 3;
      mem[16'h0000] = W_LDC;
      mem[16'h0001] = 32'hDEAD_BEEF;
      mem[16'h0002] = W_NOP;
      w = rand_alu(); w[25:22] = 4'hF;
      mem[16'h0003] = w;
      mem[16'h0004] = rand_alu();
      mem[16'h0005] = W_JMP | 32'h0000_0100;
      mem[16'h0100] = rand_alu();
      mem[16'h0101] = W_JMP | 32'h0000_0007;
      mem[16'h0007] = W_HALT;
      mem[16'h0040] = rand_alu();
      start_prog(16'h0000);
      repeat (8) @(posedge clk);
      #1 start = 1'b1; start_pc = 16'h0040;
      @(posedge clk); #1 start = 1'b0;
      wait_halt("t2");

      // Restart from HALT at 0x0020.
      mem_wait = 1;
      mem[16'h0020] = rand_alu();
      mem[16'h0021] = W_HALT;
      start_prog(16'h0020);
      wait_halt("t3");

      // PC wrap.
      mem_wait = 0;
      mem[16'hFFFF] = W_NOP;
      mem[16'h0000] = rand_alu();
      mem[16'h0001] = W_HALT;
      start_prog(16'hFFFF);
      wait_halt("t4");

      // Reset during an outstanding fetch, then a stray ack.
      mem_wait = 3;
      mem[16'h0030] = W_NOP;
      mem[16'h0031] = W_HALT;
      start_prog(16'h0030);
      @(posedge clk); #1;
      chk("rstmid_pending", imem_req, 1'b1);
      #1 rst = 1'b1;
      #1;
      chk("rstmid_misc", {pc, imem_req, halted, write, const_a}, '0);
      chk("rstmid_const", constant, '0);
      check_fields("rstmid_fields", '0);
      exp_fetch.delete();
      exp_exec.delete();
      m_pending = 1'b0; m_const = '0; m_last = '0;
      mem_en = 1'b0;
      @(posedge clk); @(posedge clk); #1 rst = 1'b0;
      imem_ack = 1'b1; imem_data = W_JMP | 32'h0000_1234;
      repeat (3) @(posedge clk);
      #1;
      chk("late_ack", {pc, imem_req, halted, write}, '0);
      imem_ack = 1'b0;
      mem_en = 1'b1;

      // Randomized loop-free programs.
      for (int t = 0; t < 25; t++) begin
         mem_wait = $urandom_range(0, 3);
         base = 16'($urandom_range(16'h0200, 16'hEF00));
         p = base;
         for (int i = 0; i < int'($urandom_range(4, 12)); i++) begin
            case ($urandom_range(0, 4))
               0, 1: begin mem[p] = rand_alu(); p = p + 16'd1; end
               2: begin
                  mem[p] = W_LDC; mem[p + 16'd1] = $urandom; p = p + 16'd2;
               end
               3: begin mem[p] = W_NOP; p = p + 16'd1; end
               default: begin
                  g = $urandom_range(1, 3);
                  mem[p] = W_JMP | {16'h0, 16'(p + 16'd1 + 16'(g))};
                  for (int j = 1; j <= g; j++) mem[p + 16'(j)] = $urandom;
                  p = p + 16'd1 + 16'(g);
               end
            endcase
         end
         mem[p] = W_HALT;
         start_prog(base);
         wait_halt("rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
